wishbone_arbiter_2m: RTL and testbench

- Two-master round-robin arbiter in front of the single master port of the existing WISHBONE interconnect.
- Master 0 is the processor-side bridge; master 1 is a second requester, e.g. a DMA or test-pattern engine.
- Grants the shared bus for whole bus cycles (cyc-framed) and muxes the request signals of the owning master onto the interconnect.
- Routes ack and read data back to the owning master only.

---
 rtl/wishbone_arbiter_2m_if.sv | 31 +++
 rtl/wishbone_arbiter_2m.sv | 179 +++++++++++++++++
 tb/tb_wishbone_arbiter_2m.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_arbiter_2m_if.sv
// Purpose: WISHBONE bus bundle shared by the arbiter's two master-side ports
//          and its single downstream port.
// Signals:
//   adr   - address, master to slave
//   dat_w - write data, master to slave
//   dat_r - read data, slave to master
//   we    - write enable
//   stb   - strobe
//   cyc   - bus cycle frame
//   sel   - byte select
//   ack   - acknowledge, slave to master
// Modports:
//   master - the side that issues cycles
//   slave  - the side that answers them
interface wishbone_arbiter_2m_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2
) ();
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              we;
  logic              stb;
  logic              cyc;
  logic [SEL_W-1:0]  sel;
  logic              ack;

  modport master (output adr, dat_w, we, stb, cyc, sel, input dat_r, ack);
  modport slave  (input adr, dat_w, we, stb, cyc, sel, output dat_r, ack);
endinterface

// File: rtl/wishbone_arbiter_2m.sv
// Purpose: two-master round-robin WISHBONE arbiter. Grants the downstream
//          port for whole cyc-framed bus cycles, muxes the owner's request
//          onto it and returns ack/read data to the owner only.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   m0    - master 0 (processor bridge), slave modport
//   m1    - master 1 (DMA / pattern engine), slave modport
//   s     - downstream interconnect port, master modport
//   gnt_o - one-hot grant, 00 when idle
//   tmo_o - one-cycle timeout pulse
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the stall timeout with
// force-release and per-master lockout. Without it tmo_o is tied low.
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | no owner, downstream outputs held at zero
// ST_OWN0 | master 0 owns the downstream port
// ST_OWN1 | master 1 owns the downstream port
module wishbone_arbiter_2m #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  wishbone_arbiter_2m_if.slave         m0,
  wishbone_arbiter_2m_if.slave         m1,
  wishbone_arbiter_2m_if.master        s,
  output logic [1:0]                   gnt_o,
  output logic                         tmo_o
);

  // Encoding is the one-hot grant so gnt_o comes straight from flops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // index of the most recent owner
  logic   req0, req1;
  logic   tmo_fire;

  logic [ADDR_W-1:0] adr_mux;
  logic [DATA_W-1:0] dat_mux;
  logic [SEL_W-1:0]  sel_mux;
  logic              we_mux, stb_mux, cyc_mux, ack0, ack1;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_VAL = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic [1:0]  lock_q, lock_d;
  logic        owner_stb;

  always_comb begin
    owner_stb = ((state_q == ST_OWN0) && m0.stb) || ((state_q == ST_OWN1) && m1.stb);
    cnt_d     = '0;
    if ((state_d == state_q) && owner_stb && !s.ack) cnt_d = cnt_q + 16'd1;
    tmo_d     = (cnt_d == TMO_VAL);
    // A lockout clears once the master has been seen with cyc low.
    lock_d    = lock_q & {m1.cyc, m0.cyc};
    if (tmo_q) begin
      if (state_q == ST_OWN0) lock_d[0] = 1'b1;
      if (state_q == ST_OWN1) lock_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
      lock_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
      lock_q <= lock_d;
    end
  end

  assign tmo_fire = tmo_q;
  assign tmo_o    = tmo_q;
  assign req0     = m0.cyc & ~lock_q[0];
  assign req1     = m1.cyc & ~lock_q[1];
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT != 0);
  assign tmo_fire       = 1'b0;
  assign tmo_o          = 1'b0;
  assign req0           = m0.cyc;
  assign req1           = m1.cyc;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (req0)     state_d = ST_OWN0;
        else if (req1)     state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0.cyc || tmo_fire) begin
          last_d  = 1'b0;
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1.cyc || tmo_fire) begin
          last_d  = 1'b1;
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Request path is purely combinational from the registered owner, so a
  // reset drops the downstream cycle without waiting for a clock.
  always_comb begin
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    we_mux  = 1'b0;
    stb_mux = 1'b0;
    cyc_mux = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    case (state_q)
      ST_OWN0: begin
        adr_mux = m0.adr;
        dat_mux = m0.dat_w;
        sel_mux = m0.sel;
        we_mux  = m0.we;
        stb_mux = m0.stb;
        cyc_mux = m0.cyc;
        ack0    = s.ack & ~tmo_fire;
      end
      ST_OWN1: begin
        adr_mux = m1.adr;
        dat_mux = m1.dat_w;
        sel_mux = m1.sel;
        we_mux  = m1.we;
        stb_mux = m1.stb;
        cyc_mux = m1.cyc;
        ack1    = s.ack & ~tmo_fire;
      end
      default: ;
    endcase
  end

  assign s.adr    = adr_mux;
  assign s.dat_w  = dat_mux;
  assign s.sel    = sel_mux;
  assign s.we     = we_mux;
  assign s.stb    = stb_mux;
  assign s.cyc    = cyc_mux;
  assign m0.ack   = ack0;
  assign m1.ack   = ack1;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign gnt_o    = state_q;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
module tb_wishbone_arbiter_2m;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gnt;
  logic       tmo;

  wishbone_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(2)) m0_if ();
  wishbone_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(2)) m1_if ();
  wishbone_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(2)) s_if ();

  wishbone_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .SEL_W(2), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt_o (gnt),
    .tmo_o (tmo)
  );

  always #5 clk = ~clk;

  // bench-side stimulus
  logic        cyc_b [2];
  logic        stb_b [2];
  logic        we_b  [2];
  logic [31:0] adr_b [2];
  logic [31:0] dat_b [2];
  logic [1:0]  sel_b [2];
  logic        s_ack_b;
  logic [31:0] s_dat_b;

  // reference model: owner index (-1 = nobody), last owner, stall count
  int own_m, last_m, cnt_m;
  bit tmo_m;
  bit lock_m [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply();
    m0_if.cyc = cyc_b[0]; m0_if.stb = stb_b[0]; m0_if.we = we_b[0];
    m0_if.adr = adr_b[0]; m0_if.dat_w = dat_b[0]; m0_if.sel = sel_b[0];
    m1_if.cyc = cyc_b[1]; m1_if.stb = stb_b[1]; m1_if.we = we_b[1];
    m1_if.adr = adr_b[1]; m1_if.dat_w = dat_b[1]; m1_if.sel = sel_b[1];
    s_if.ack = s_ack_b; s_if.dat_r = s_dat_b;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      cyc_b[i] = 0; stb_b[i] = 0; we_b[i] = 0;
      adr_b[i] = '0; dat_b[i] = '0; sel_b[i] = '0;
    end
    s_ack_b = 0; s_dat_b = '0;
    apply();
  endtask

  task automatic model_reset();
    own_m = -1; last_m = 1; cnt_m = 0; tmo_m = 0;
    lock_m[0] = 0; lock_m[1] = 0;
  endtask

  task automatic model_update();
    bit req [2];
    bit stalled;
    int nxt;
    for (int i = 0; i < 2; i++) req[i] = cyc_b[i] && !lock_m[i];
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 2; i++) if (!cyc_b[i]) lock_m[i] = 0;
`endif
    nxt = own_m;
    if (own_m < 0) begin
      if (req[0] && req[1]) nxt = 1 - last_m;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
    end else if (!cyc_b[own_m] || tmo_m) begin
      if (tmo_m) lock_m[own_m] = 1;
      last_m = own_m;
      nxt = req[1 - own_m] ? 1 - own_m : -1;
    end
    stalled = (own_m >= 0) && stb_b[own_m] && !s_ack_b;
    cnt_m = (nxt == own_m && stalled) ? cnt_m + 1 : 0;
`ifdef WB_ARB_TIMEOUT_EN
    tmo_m = (cnt_m == TMO);
`endif
    own_m = nxt;
  endtask

  task automatic check_outputs();
    logic [1:0]  e_gnt;
    logic        e_cyc, e_stb, e_we, e_ack0, e_ack1;
    logic [31:0] e_adr, e_dat;
    logic [1:0]  e_sel;
    e_gnt = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (own_m >= 0) begin
      e_gnt = (own_m == 0) ? 2'b01 : 2'b10;
      e_cyc = cyc_b[own_m]; e_stb = stb_b[own_m]; e_we = we_b[own_m];
      e_adr = adr_b[own_m]; e_dat = dat_b[own_m]; e_sel = sel_b[own_m];
    end
    e_ack0 = (own_m == 0) && s_ack_b && !tmo_m;
    e_ack1 = (own_m == 1) && s_ack_b && !tmo_m;
    check_val("gnt",   gnt, e_gnt);
    check_val("tmo",   tmo, tmo_m);
    check_val("s_cyc", s_if.cyc, e_cyc);
    check_val("s_stb", s_if.stb, e_stb);
    check_val("s_we",  s_if.we, e_we);
    check_val("s_adr", s_if.adr, e_adr);
    check_val("s_dat", s_if.dat_w, e_dat);
    check_val("s_sel", s_if.sel, e_sel);
    check_val("m0_ack", m0_if.ack, e_ack0);
    check_val("m1_ack", m1_if.ack, e_ack1);
    if (e_ack0) check_val("m0_dat", m0_if.dat_r, s_dat_b);
    if (e_ack1) check_val("m1_dat", m1_if.dat_r, s_dat_b);
  endtask

  task automatic settle();
    #3;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Asserts reset with current inputs still driven, checks the bus drops
  // before any clock edge, then releases at posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_val("rst_gnt", gnt, 2'b00);
    check_val("rst_cyc", s_if.cyc, 1'b0);
    check_val("rst_stb", s_if.stb, 1'b0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] beat_dat [3];
  int tmo_at, tmo_hits;
  bit slow_slave;

  initial begin
    beat_dat[0] = 32'h11; beat_dat[1] = 32'h22; beat_dat[2] = 32'h33;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    settle();
    check_val("reset_tmo", tmo, 1'b0);
    tick();

    // single master write
    cyc_b[0] = 1; stb_b[0] = 1; we_b[0] = 1;
    adr_b[0] = 32'h4; dat_b[0] = 32'hDEADBEEF; sel_b[0] = 2'b11;
    apply();
    settle();
    check_val("wr_latency_gnt", gnt, 2'b00);
    tick();
    settle();
    check_val("wr_gnt", gnt, 2'b01);
    check_val("wr_adr", s_if.adr, 32'h4);
    check_val("wr_dat", s_if.dat_w, 32'hDEADBEEF);
    check_val("wr_we",  s_if.we, 1'b1);
    tick();
    s_ack_b = 1; apply();
    settle();
    check_val("wr_ack0", m0_if.ack, 1'b1);
    check_val("wr_ack1", m1_if.ack, 1'b0);
    tick();
    idle_inputs();
    settle(); tick();
    settle(); tick();

    // simultaneous request right after reset
    do_reset();
    cyc_b[0] = 1; stb_b[0] = 1; cyc_b[1] = 1; stb_b[1] = 1; apply();
    settle(); tick();
    settle();
    check_val("rr_first", gnt, 2'b01);
    cyc_b[0] = 0; stb_b[0] = 0; apply();
    settle(); tick();
    settle();
    check_val("rr_handover", gnt, 2'b10);
    cyc_b[1] = 0; stb_b[1] = 0; apply();
    tick();
    settle();
    check_val("rr_idle", gnt, 2'b00);
    cyc_b[0] = 1; stb_b[0] = 1; cyc_b[1] = 1; stb_b[1] = 1; apply();
    tick();
    settle();
    check_val("rr_again", gnt, 2'b01);
    idle_inputs();
    tick(); settle(); tick();

    // m1 multi-beat read while m0 waits
    cyc_b[1] = 1; apply();
    settle(); tick();
    cyc_b[0] = 1; stb_b[0] = 1; apply();
    for (int k = 0; k < 3; k++) begin
      stb_b[1] = 1; we_b[1] = 0; adr_b[1] = 32'h100 + k;
      s_ack_b = 1; s_dat_b = beat_dat[k]; apply();
      settle();
      check_val("rd_gnt",  gnt, 2'b10);
      check_val("rd_ack1", m1_if.ack, 1'b1);
      check_val("rd_dat1", m1_if.dat_r, beat_dat[k]);
      check_val("rd_ack0", m0_if.ack, 1'b0);
      tick();
      stb_b[1] = 0; s_ack_b = 0; apply();
      settle(); tick();
    end
    cyc_b[1] = 0; apply();
    settle(); tick();
    settle();
    check_val("rd_release", gnt, 2'b01);
    idle_inputs();
    tick(); settle(); tick();

    // reset while m1 owns with stb high
    cyc_b[1] = 1; stb_b[1] = 1; apply();
    settle(); tick();
    settle();
    check_val("pre_rst_gnt", gnt, 2'b10);
    do_reset();
    cyc_b[0] = 1; cyc_b[1] = 1; apply();
    settle(); tick();
    settle();
    check_val("post_rst_m0", gnt, 2'b01);
    idle_inputs();
    tick(); settle(); tick();

    // stray ack while idle
    s_ack_b = 1; s_dat_b = 32'hCAFE; apply();
    settle();
    check_val("stray_ack0", m0_if.ack, 1'b0);
    check_val("stray_ack1", m1_if.ack, 1'b0);
    tick();
    idle_inputs();

    // stalled m0 with m1 pending
    do_reset();
    cyc_b[0] = 1; stb_b[0] = 1; cyc_b[1] = 1; stb_b[1] = 1; apply();
    tmo_at = -1; tmo_hits = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (tmo === 1'b1) begin
        tmo_hits++;
        if (tmo_at < 0) tmo_at = c;
      end
      tick();
    end
    settle();
`ifdef WB_ARB_TIMEOUT_EN
    check_val("tmo_cycle", 64'(tmo_at), 64'(5));
    check_val("tmo_width", 64'(tmo_hits), 64'(1));
    check_val("tmo_moved", gnt, 2'b10);
    cyc_b[1] = 0; stb_b[1] = 0; apply();
    settle(); tick();
    settle();
    check_val("tmo_locked", gnt, 2'b00);
    cyc_b[0] = 0; stb_b[0] = 0; apply();
    settle(); tick();
    cyc_b[0] = 1; stb_b[0] = 1; apply();
    settle(); tick();
    settle();
    check_val("tmo_unlocked", gnt, 2'b01);
`else
    check_val("tmo_never", 64'(tmo_hits), 64'(0));
    check_val("tmo_keep", gnt, 2'b01);
`endif
    idle_inputs();
    tick(); settle(); tick();

    // randomized traffic
    do_reset();
    slow_slave = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) slow_slave = !slow_slave;
      for (int i = 0; i < 2; i++) begin
        if (!cyc_b[i]) cyc_b[i] = ($urandom_range(0, 3) == 0);
        else           cyc_b[i] = ($urandom_range(0, 7) != 0);
        stb_b[i] = cyc_b[i] && ($urandom_range(0, 2) != 0);
        we_b[i]  = $urandom_range(0, 1) == 1;
        adr_b[i] = $urandom;
        dat_b[i] = $urandom;
        sel_b[i] = 2'($urandom_range(0, 3));
      end
      s_ack_b = slow_slave ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
      s_dat_b = $urandom;
      apply();
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
